// File: rtl/bram_pkg.sv
// Shared types for the simple-dual-port block RAM family.
package bram_pkg;

  typedef enum logic {
    RDW_WRITE_FIRST,
    RDW_READ_FIRST
  } rdw_mode_e;

  typedef enum logic {
    CLEARING,
    READY
  } clear_state_e;

endpackage

// File: rtl/bram_sdp_if.sv
// Write/read port bundle of bram_sdp; master is the user, slave is the RAM.
interface bram_sdp_if #(
  parameter int unsigned AddrBits       = 7,
  parameter int unsigned WordLengthBits = 8,
  parameter int unsigned NumBytes       = 1
) ();

  logic                      wr_enable;
  logic [AddrBits-1:0]       wr_address;
  logic [NumBytes-1:0]       wr_byte_enable;
  logic [WordLengthBits-1:0] wr_data;
  logic                      rd_enable;
  logic [AddrBits-1:0]       rd_address;
  logic [WordLengthBits-1:0] rd_data;
  logic                      rd_valid;
  logic                      ready;

  modport master (
    output wr_enable, wr_address, wr_byte_enable, wr_data, rd_enable, rd_address,
    input  rd_data, rd_valid, ready
  );

  modport slave (
    input  wr_enable, wr_address, wr_byte_enable, wr_data, rd_enable, rd_address,
    output rd_data, rd_valid, ready
  );

endinterface

// File: rtl/bram_clear_sequencer.sv
// Walks every address once after reset, requesting an all-zero write, then raises ready.
module bram_clear_sequencer
  import bram_pkg::*;
#(
  parameter int unsigned NumWords = 128,
  parameter int unsigned AddrBits = $clog2(NumWords)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                clear_write,
  output logic [AddrBits-1:0] clear_address,
  output logic                ready
);

  localparam logic [AddrBits-1:0] LastAddr = AddrBits'(NumWords - 1);

  clear_state_e        state_q, state_d;
  logic [AddrBits-1:0] addr_q, addr_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLEARING;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    clear_write = 1'b0;
    case (state_q)
      CLEARING: begin
        clear_write = 1'b1;
        if (addr_q == LastAddr) begin
          state_d = READY;
        end else begin
          addr_d = addr_q + AddrBits'(1);
        end
      end
      READY: ;
      default: state_d = CLEARING;
    endcase
  end

  assign clear_address = addr_q;
  assign ready         = (state_q == READY);

endmodule

// File: rtl/bram_sdp.sv
// Simple-dual-port RAM: byte-lane writes, 1/2-cycle registered reads,
// selectable same-address collision policy and optional post-reset zeroing.
module bram_sdp
  import bram_pkg::*;
#(
  parameter int unsigned WordLengthBits  = 8,
  parameter int unsigned NumWords        = 128,
  parameter int unsigned ByteLengthBits  = 8,
  parameter int unsigned ReadLatency     = 1,
  parameter rdw_mode_e   ReadDuringWrite = RDW_WRITE_FIRST,
  parameter bit          ClearOnReset    = 1'b1
) (
  input logic       clk,
  input logic       rst,
  bram_sdp_if.slave bus
);

  localparam int unsigned AddrBits = $clog2(NumWords);
  localparam int unsigned NumBytes = WordLengthBits / ByteLengthBits;
  localparam logic [AddrBits:0] Depth = (AddrBits + 1)'(NumWords);

  if (ReadLatency != 1 && ReadLatency != 2) begin : g_bad_latency
    $error("bram_sdp: ReadLatency must be 1 or 2");
  end
  if (WordLengthBits % ByteLengthBits != 0) begin : g_bad_lanes
    $error("bram_sdp: WordLengthBits must be a multiple of ByteLengthBits");
  end

  logic                clear_write;
  logic [AddrBits-1:0] clear_address;
  logic                ready;

  if (ClearOnReset) begin : g_clear
    bram_clear_sequencer #(
      .NumWords(NumWords),
      .AddrBits(AddrBits)
    ) u_clear (
      .clk           (clk),
      .rst           (rst),
      .clear_write   (clear_write),
      .clear_address (clear_address),
      .ready         (ready)
    );
  end else begin : g_no_clear
    assign clear_write   = 1'b0;
    assign clear_address = '0;
    assign ready         = 1'b1;
  end

  logic [WordLengthBits-1:0] mem_q [NumWords];

  logic                      wr_accept, wr_in_range;
  logic                      rd_accept, rd_in_range;
  logic                      collision;
  logic [WordLengthBits-1:0] stored_word, read_word;

  always_comb begin
    wr_accept   = ready & bus.wr_enable;
    wr_in_range = ({1'b0, bus.wr_address} < Depth);
    rd_accept   = ready & bus.rd_enable;
    rd_in_range = ({1'b0, bus.rd_address} < Depth);
    collision   = wr_accept & wr_in_range & (bus.wr_address == bus.rd_address);
    stored_word = rd_in_range ? mem_q[bus.rd_address] : '0;
    read_word   = stored_word;
    // Write-first bypass: the array still holds the old word this cycle.
    if (ReadDuringWrite == RDW_WRITE_FIRST && collision) begin
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (bus.wr_byte_enable[i]) begin
          read_word[i*ByteLengthBits +: ByteLengthBits] = bus.wr_data[i*ByteLengthBits +: ByteLengthBits];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clear_write) begin
      mem_q[clear_address] <= '0;
    end else if (wr_accept && wr_in_range) begin
      for (int unsigned i = 0; i < NumBytes; i++) begin
        if (bus.wr_byte_enable[i]) begin
          mem_q[bus.wr_address][i*ByteLengthBits +: ByteLengthBits] <= bus.wr_data[i*ByteLengthBits +: ByteLengthBits];
        end
      end
    end
  end

  logic                      ret_valid;
  logic [WordLengthBits-1:0] ret_data;

  if (ReadLatency == 1) begin : g_lat1
    assign ret_valid = rd_accept;
    assign ret_data  = read_word;
  end else begin : g_lat2
    logic                      s1_valid_q, s1_valid_d;
    logic [WordLengthBits-1:0] s1_data_q, s1_data_d;

    always_comb begin
      s1_valid_d = rd_accept;
      s1_data_d  = s1_data_q;
      if (rd_accept) begin
        s1_data_d = read_word;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        s1_valid_q <= 1'b0;
        s1_data_q  <= '0;
      end else begin
        s1_valid_q <= s1_valid_d;
        s1_data_q  <= s1_data_d;
      end
    end

    assign ret_valid = s1_valid_q;
    assign ret_data  = s1_data_q;
  end

  logic                      rd_valid_q, rd_valid_d;
  logic [WordLengthBits-1:0] rd_data_q, rd_data_d;

  always_comb begin
    rd_valid_d = ret_valid;
    rd_data_d  = rd_data_q;
    if (ret_valid) begin
      rd_data_d = ret_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.ready    = ready;

endmodule

// File: tb/tb_bram_sdp.sv
// Three bram_sdp configurations driven in lockstep and checked against an array model.
module tb_bram_sdp;
  import bram_pkg::*;

  localparam int NW  [3] = '{100, 128, 128};
  localparam int RL  [3] = '{1, 2, 1};
  localparam bit WF  [3] = '{1'b1, 1'b0, 1'b0};
  localparam bit CLR [3] = '{1'b1, 1'b1, 1'b0};

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_enable;
  logic [6:0]  wr_address;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic        rd_enable;
  logic [6:0]  rd_address;

  logic [31:0] rdd [3];
  logic        rdv [3];
  logic        rdy [3];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bram_sdp_if #(.AddrBits(7), .WordLengthBits(32), .NumBytes(4)) ifs [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    assign ifs[g].wr_enable      = wr_enable;
    assign ifs[g].wr_address     = wr_address;
    assign ifs[g].wr_byte_enable = wr_be;
    assign ifs[g].wr_data        = wr_data;
    assign ifs[g].rd_enable      = rd_enable;
    assign ifs[g].rd_address     = rd_address;
    assign rdd[g] = ifs[g].rd_data;
    assign rdv[g] = ifs[g].rd_valid;
    assign rdy[g] = ifs[g].ready;

    bram_sdp #(
      .WordLengthBits  (32),
      .NumWords        (NW[g]),
      .ByteLengthBits  (8),
      .ReadLatency     (RL[g]),
      .ReadDuringWrite (WF[g] ? RDW_WRITE_FIRST : RDW_READ_FIRST),
      .ClearOnReset    (CLR[g])
    ) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (ifs[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit [31:0] mem_m     [3][128];
  bit        ready_m   [3];
  int        cnt_m     [3];
  bit        exp_valid [3];
  bit [31:0] exp_data  [3];
  bit        pend_v    [3];
  bit [31:0] pend_d    [3];

  function automatic bit [31:0] merge(bit [31:0] old, bit [31:0] nw, bit [3:0] m);
    bit [31:0] r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction

  function automatic bit [31:0] model_read(int k);
    if (int'(rd_address) >= NW[k]) return 32'h0;
    if (WF[k] && wr_enable && ready_m[k] && wr_address == rd_address)
      return merge(mem_m[k][rd_address], wr_data, wr_be);
    return mem_m[k][rd_address];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        ready_m[k]   <= !CLR[k];
        cnt_m[k]     <= 0;
        exp_valid[k] <= 1'b0;
        exp_data[k]  <= 32'h0;
        pend_v[k]    <= 1'b0;
        pend_d[k]    <= 32'h0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (ready_m[k] && wr_enable && int'(wr_address) < NW[k])
          mem_m[k][wr_address] <= merge(mem_m[k][wr_address], wr_data, wr_be);
        if (RL[k] == 1) begin
          exp_valid[k] <= ready_m[k] && rd_enable;
          if (ready_m[k] && rd_enable) exp_data[k] <= model_read(k);
        end else begin
          exp_valid[k] <= pend_v[k];
          if (pend_v[k]) exp_data[k] <= pend_d[k];
          pend_v[k] <= ready_m[k] && rd_enable;
          pend_d[k] <= model_read(k);
        end
        if (!ready_m[k]) begin
          cnt_m[k] <= cnt_m[k] + 1;
          if (cnt_m[k] + 1 == NW[k]) begin
            ready_m[k] <= 1'b1;
            for (int a = 0; a < 128; a++) mem_m[k][a] <= 32'h0;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("u%0d ready", k),    rdy[k], ready_m[k]);
      chk($sformatf("u%0d rd_valid", k), rdv[k], exp_valid[k]);
      chk($sformatf("u%0d rd_data", k),  rdd[k], exp_data[k]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    wr_enable = 1'b0;
    rd_enable = 1'b0;
  endtask

  task automatic wr(input logic [6:0] a, input logic [31:0] d, input logic [3:0] m);
    @(negedge clk);
    wr_enable = 1'b1; wr_address = a; wr_data = d; wr_be = m;
    @(negedge clk);
    wr_enable = 1'b0;
  endtask

  task automatic read_check(input string name, input logic [6:0] a,
                            input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    @(negedge clk);
    rd_enable = 1'b1; rd_address = a;
    @(negedge clk);
    rd_enable = 1'b0;
    chk({name, " u0 valid"}, rdv[0], 32'd1);
    chk({name, " u0 data"},  rdd[0], e0);
    chk({name, " u2 valid"}, rdv[2], 32'd1);
    chk({name, " u2 data"},  rdd[2], e2);
    @(negedge clk);
    chk({name, " u1 valid"}, rdv[1], 32'd1);
    chk({name, " u1 data"},  rdd[1], e1);
  endtask

  task automatic wait_ready(input string name, input int offset);
    int c0 = 0;
    int c1 = 0;
    for (int i = 1; i <= 400; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (c0 == 0 && rdy[0]) c0 = i + offset;
      if (c1 == 0 && rdy[1]) c1 = i + offset;
      if (c0 != 0 && c1 != 0) break;
    end
    chk({name, " u0 ready cycles"}, c0, 32'd100);
    chk({name, " u1 ready cycles"}, c1, 32'd128);
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      wr_enable  = ($urandom_range(0, 1) == 1);
      wr_address = 7'($urandom_range(0, 127));
      wr_be      = 4'($urandom_range(0, 15));
      wr_data    = $urandom;
      rd_enable  = ($urandom_range(0, 3) != 0);
      rd_address = ($urandom_range(0, 3) == 0) ? wr_address : 7'($urandom_range(0, 127));
    end
    @(negedge clk);
    idle();
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1;
    wr_address = '0; wr_be = '0; wr_data = '0; rd_address = '0;
    idle();
    repeat (3) @(negedge clk);
    chk("reset u0 ready", rdy[0], 32'd0);
    chk("reset u2 ready", rdy[2], 32'd1);
    chk("reset u1 rd_valid", rdv[1], 32'd0);

    // Clear: a write during clearing must be lost on the clearing instances.
    rst = 1'b0;
    wr_enable = 1'b1; wr_address = 7'd5; wr_data = 32'hAA; wr_be = 4'hF;
    @(negedge clk);
    wr_enable = 1'b0;
    wait_ready("clear", 1);
    read_check("clear rd5", 7'd5, 32'h0, 32'h0, 32'hAA);

    for (int a = 0; a < 128; a++) wr(7'(a), $urandom, 4'hF);

    wr(7'd3, 32'h11223344, 4'hF);
    wr(7'd3, 32'hAABBCCDD, 4'b0101);
    read_check("lanes", 7'd3, 32'h11BB33DD, 32'h11BB33DD, 32'h11BB33DD);

    wr(7'd0, 32'h01, 4'hF);
    wr(7'd1, 32'h02, 4'hF);
    wr(7'd2, 32'h03, 4'hF);
    for (int j = 0; j <= 5; j++) begin
      @(negedge clk);
      if (j >= 1) begin
        chk($sformatf("lat2 valid s%0d", j), rdv[1], (j >= 2 && j <= 4) ? 32'd1 : 32'd0);
        if (j >= 2 && j <= 4) chk($sformatf("lat2 data s%0d", j), rdd[1], 32'(j - 1));
        chk($sformatf("lat1 valid s%0d", j), rdv[0], (j <= 3) ? 32'd1 : 32'd0);
        if (j <= 3) chk($sformatf("lat1 data s%0d", j), rdd[0], 32'(j));
      end
      rd_enable  = (j < 3);
      rd_address = 7'(j);
    end

    wr(7'd7, 32'h55, 4'hF);
    @(negedge clk);
    wr_enable = 1'b1; wr_address = 7'd7; wr_data = 32'hA0; wr_be = 4'hF;
    rd_enable = 1'b1; rd_address = 7'd7;
    @(negedge clk);
    idle();
    chk("rdw write-first u0", rdd[0], 32'hA0);
    chk("rdw read-first u2",  rdd[2], 32'h55);
    @(negedge clk);
    chk("rdw read-first u1",  rdd[1], 32'h55);

    wr(7'd99,  32'h3C, 4'hF);
    wr(7'd100, 32'hFF, 4'hF);
    read_check("bound99",  7'd99,  32'h3C, 32'h3C, 32'h3C);
    read_check("bound100", 7'd100, 32'h00, 32'hFF, 32'hFF);

    random_phase(2000);

    // Reset in the middle of the clear walk, at clear address 40.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (40) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("midclear u0 ready", rdy[0], 32'd0);
    chk("midclear u1 ready", rdy[1], 32'd0);
    #2 rst = 1'b0;
    wait_ready("midclear", 0);

    random_phase(500);

    // Reset with reads in flight on every instance.
    wr(7'd3, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    rd_enable = 1'b1; rd_address = 7'd3;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("midread u%0d rd_valid", k), rdv[k], 32'd0);
      chk($sformatf("midread u%0d rd_data", k),  rdd[k], 32'd0);
    end
    #2 rst = 1'b0;
    rd_enable = 1'b0;
    wait_ready("midread", 0);

    random_phase(300);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bram_sdp.md
Name: bram_sdp

Overview:
- Parametrised simple-dual-port block RAM; successor to the single-port bram.
- Independent write and read ports on one clock.
- Adds byte-lane write enables, selectable 1- or 2-cycle read latency, selectable read-during-write mode, and an optional post-reset clear sequencer that zeroes the array.
- Used as the storage primitive under sample buffers and FIFOs in the rfkit datapath.

Parameters:
- WordLengthBits, 8, data word width; must be a multiple of ByteLengthBits.
- NumWords, 128, memory depth (≥2; need not be a power of two).
- ByteLengthBits, 8, width of one write-enable lane.
- ReadLatency, 1, cycles from accepted read to rd_data/rd_valid; legal values 1 or 2.
- ReadDuringWrite, RDW_WRITE_FIRST, same-address collision policy: RDW_WRITE_FIRST or RDW_READ_FIRST.
- ClearOnReset, 1, when 1 the array is zeroed after reset; when 0 ready is high straight out of reset.
- Derived: AddrBits = $clog2(NumWords); NumBytes = WordLengthBits/ByteLengthBits.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- wr_enable  in  1  write request
- wr_address  in  AddrBits  write address
- wr_byte_enable  in  NumBytes  per-lane write mask, lane 0 = LSBs
- wr_data  in  WordLengthBits  write data
- rd_enable  in  1  read request
- rd_address  in  AddrBits  read address
- rd_data  out  WordLengthBits  read data
- rd_valid  out  1  one-cycle pulse marking new rd_data
- ready  out  1  high when user accesses are accepted

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: rd_data = 0, rd_valid = 0, read pipeline flushed, ready = !ClearOnReset. Array contents are not reset directly.
- Clear FSM (ClearOnReset = 1)
  - States: CLEARING and READY; reset forces CLEARING with clear_address = 0.
  - In CLEARING, each edge with rst low writes all-zero to mem[clear_address] and increments clear_address.
  - After the write to NumWords-1, go to READY. ready rises after edge NumWords, counting the first edge with rst low as edge 1.
  - rst asserted mid-clear restarts the clear from address 0.
  - While ready = 0, user writes are ignored, reads are not accepted, and rd_valid stays 0.
- Write: on an edge with ready & wr_enable, for each lane i with wr_byte_enable[i] = 1, set mem[wr_address] lane i to wr_data lane i. Disabled lanes are untouched. wr_byte_enable = 0 is a no-op.
- Read acceptance: a read is accepted on edge N when ready & rd_enable.
  - ReadLatency 1: rd_data updates and rd_valid = 1 after edge N.
  - ReadLatency 2: the word is captured at edge N; rd_data and rd_valid present after edge N+1.
  - Back-to-back reads are accepted every cycle, giving full throughput.
  - rd_valid drops the cycle after each pulse unless another read retires.
  - rd_data holds its last value when no read retires.
- Read-during-write (same edge, rd_address == wr_address, both accepted):
  - WRITE_FIRST: read returns the merged word (enabled lanes new, disabled lanes old). With a tied address, latency 1 and full byte enables, this matches the previous bram.
  - READ_FIRST: read returns the pre-write word.
- Out-of-range addresses (≥ NumWords): writes are dropped; reads return 0 with rd_valid still pulsed.
- Reset mid-read: rd_valid and rd_data clear immediately; in-flight reads are discarded.
- Elaboration-time checks: assertion failure if ReadLatency ∉ {1,2} or WordLengthBits % ByteLengthBits ≠ 0.

Decomposition:
- Package bram_pkg
  - rdw_mode_e {RDW_WRITE_FIRST, RDW_READ_FIRST}
  - clear_state_e {CLEARING, READY}
- Sub-module bram_clear_sequencer
  - Inputs: clk, rst, NumWords.
  - Outputs: clear_write, clear_address, ready.
  - The top muxes its write port onto the array while ready = 0.
- Storage array, byte-lane write, collision logic and read pipeline live in bram_sdp.

Test Plan:
- Clear: configure NumWords=128, ClearOnReset=1, write 0xAA to address 5 before ready, then release rst. Required: ready rises exactly 128 cycles after release, and a read of 5 then returns 0x00 with rd_valid.
- Byte lanes: configure WordLengthBits=32, write 0x11223344 to address 3 with mask 4'b1111, then 0xAABBCCDD with mask 4'b0101. Required: a read of 3 returns 0x11BB33DD.
- Latency: configure ReadLatency=2, write 0x01/0x02/0x03 to addresses 0/1/2, then read 0,1,2 on consecutive edges. Required: rd_valid is high for 3 consecutive cycles starting 2 cycles after the first read, with data 0x01,0x02,0x03.
- Collision: preload address 7 = 0x55, then write 0xA0 and read 7 on the same edge. Required: WRITE_FIRST returns 0xA0; READ_FIRST returns 0x55.
- Boundary: configure NumWords=100, write 0x3C to address 99 and 0xFF to address 100, then read both. Required: address 99 returns 0x3C; address 100 returns 0x00 with rd_valid pulsed.
- Reset mid-operation: assert rst for 3 ns during the clear at address 40 and during an in-flight read. Required: rd_valid drops immediately, and ready rises NumWords cycles after release.
